frame_scan_controller: RTL and testbench

Sequences the pixel renderer across one full frame. It generates pixel_x/pixel_y in raster order and samples the renderer's combinational pixel_color. Each pixel is pushed to the display write interface through a valid/ready handshake.
Ball and paddle positions are snapshotted at frame start, so game logic can update positions mid-frame without tearing. Sits between game-state logic, the renderer and the LCD writer.

---
 rtl/frame_scan_controller.sv | 128 ++++++++++++
 tb/tb_frame_scan_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_controller.sv
// Raster-order frame scanner feeding renderer colours to the LCD writer over valid/ready.
// Optional FRAME_COUNT_EN macro adds a 16-bit completed-frame counter on frame_count.
module frame_scan_controller #(
  parameter int unsigned MAX_H   = 320,
  parameter int unsigned MAX_V   = 240,
  parameter int unsigned COORD_W = 9,
  parameter int unsigned COLOR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_frame,
  input  logic [COORD_W-1:0] ball_x_in,
  input  logic [COORD_W-1:0] ball_y_in,
  input  logic [COORD_W-1:0] paddle_1_x_in,
  input  logic [COORD_W-1:0] paddle_1_y_in,
  input  logic [COORD_W-1:0] paddle_2_x_in,
  input  logic [COORD_W-1:0] paddle_2_y_in,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_1_x,
  output logic [COORD_W-1:0] paddle_1_y,
  output logic [COORD_W-1:0] paddle_2_x,
  output logic [COORD_W-1:0] paddle_2_y,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  input  logic [COLOR_W-1:0] pixel_color_in,
  output logic [COLOR_W-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam logic [COORD_W-1:0] XLast = COORD_W'(MAX_H - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(MAX_V - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e state_q, state_d;
  logic   start, load, last_pix, drain_done;

  assign last_pix = (pixel_x == XLast) && (pixel_y == YLast);

  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_frame) state_d = StScan;
      StScan:  if (load && last_pix) state_d = StDrain;
      StDrain: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    start      = (state_q == StIdle) && start_frame;
    load       = (state_q == StScan) && (!out_valid || out_ready);
    drain_done = (state_q == StDrain) && out_ready;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ball_x     <= '0;
      ball_y     <= '0;
      paddle_1_x <= '0;
      paddle_1_y <= '0;
      paddle_2_x <= '0;
      paddle_2_y <= '0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= drain_done;
      // Snapshot once per frame so mid-frame game updates cannot tear the image.
      if (start) begin
        ball_x     <= ball_x_in;
        ball_y     <= ball_y_in;
        paddle_1_x <= paddle_1_x_in;
        paddle_1_y <= paddle_1_y_in;
        paddle_2_x <= paddle_2_x_in;
        paddle_2_y <= paddle_2_y_in;
        pixel_x    <= '0;
        pixel_y    <= '0;
      end
      if (load) begin
        out_data  <= pixel_color_in;
        out_valid <= 1'b1;
        out_last  <= last_pix;
        if (!last_pix) begin
          if (pixel_x == XLast) begin
            pixel_x <= '0;
            pixel_y <= pixel_y + 1'b1;
          end else begin
            pixel_x <= pixel_x + 1'b1;
          end
        end
      end
      if (drain_done) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge clock) begin
    if (reset)           frame_count_q <= '0;
    else if (frame_done) frame_count_q <= frame_count_q + 16'd1;
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_frame_scan_controller.sv
// Scoreboard bench for frame_scan_controller on a 4x3 frame; expected pixels are queued at
// frame start and matched against accepted beats.
module tb_frame_scan_controller;

  localparam int MAX_H   = 4;
  localparam int MAX_V   = 3;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 16;
  localparam int NPIX    = MAX_H * MAX_V;

  logic clock = 1'b0;
  logic reset, start_frame, out_ready;
  logic [COORD_W-1:0] ball_x_in, ball_y_in, paddle_1_x_in, paddle_1_y_in;
  logic [COORD_W-1:0] paddle_2_x_in, paddle_2_y_in;
  logic [COORD_W-1:0] ball_x, ball_y, paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y;
  logic [COORD_W-1:0] pixel_x, pixel_y;
  logic [COLOR_W-1:0] pixel_color_in, out_data, color_base;
  logic               out_valid, out_last, busy, frame_done;
  logic [15:0]        frame_count;

  int checks = 0;
  int errors = 0;
  int stall_err, ball_err;

  logic [COLOR_W-1:0] exp_q[$];
  logic               exp_last_q[$];
  logic [COLOR_W-1:0] got_q[$];
  logic               got_last_q[$];

  always #5 clock = ~clock;

  assign pixel_color_in = color_base + COLOR_W'(pixel_y) * COLOR_W'(MAX_H) + COLOR_W'(pixel_x);

  frame_scan_controller #(
    .MAX_H  (MAX_H),
    .MAX_V  (MAX_V),
    .COORD_W(COORD_W),
    .COLOR_W(COLOR_W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_frame   (start_frame),
    .ball_x_in     (ball_x_in),
    .ball_y_in     (ball_y_in),
    .paddle_1_x_in (paddle_1_x_in),
    .paddle_1_y_in (paddle_1_y_in),
    .paddle_2_x_in (paddle_2_x_in),
    .paddle_2_y_in (paddle_2_y_in),
    .ball_x        (ball_x),
    .ball_y        (ball_y),
    .paddle_1_x    (paddle_1_x),
    .paddle_1_y    (paddle_1_y),
    .paddle_2_x    (paddle_2_x),
    .paddle_2_y    (paddle_2_y),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_color_in(pixel_color_in),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_count   (frame_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_q.push_back(color_base + COLOR_W'(i));
      exp_last_q.push_back(i == NPIX - 1);
    end
  endtask

  // Runs until frame_done; mode 0 = always ready, mode 1 = ready pattern 1,0,0.
  task automatic collect(input int mode, input logic [COORD_W-1:0] exp_ball,
                         input logic [COORD_W-1:0] new_ball, output int done_iter);
    logic [COLOR_W-1:0] hold_data;
    logic [COORD_W-1:0] hold_x;
    logic               stalled;
    done_iter = -1;
    stall_err = 0;
    ball_err  = 0;
    got_q.delete();
    got_last_q.delete();
    for (int i = 0; i < 200; i++) begin
      out_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
      if (i == 5) ball_x_in = new_ball;
      if (ball_x !== exp_ball) ball_err++;
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_x    = pixel_x;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_last_q.push_back(out_last);
      end
      step();
      if (stalled && (out_data !== hold_data || out_valid !== 1'b1 || pixel_x !== hold_x))
        stall_err++;
      if (frame_done === 1'b1) begin
        done_iter = i;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_frame = 1'b0; out_ready = 1'b0; color_base = '0;
    ball_x_in = '0; ball_y_in = '0; paddle_1_x_in = '0; paddle_1_y_in = '0;
    paddle_2_x_in = '0; paddle_2_y_in = '0;
    step(); step();
    checks++;
    if ({out_valid, out_last, busy, frame_done} !== 4'b0 || out_data !== '0 ||
        pixel_x !== '0 || pixel_y !== '0 || ball_x !== '0 || paddle_2_y !== '0 ||
        frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b data=%h x=%0d y=%0d cnt=%0d, want all 0",
               out_valid, out_last, busy, frame_done, out_data, pixel_x, pixel_y, frame_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int done_iter;
    color_base = '0;
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || pixel_x !== '0 || pixel_y !== '0) begin
      errors++;
      $display("FAIL basic_start: busy=%b valid=%b x=%0d y=%0d, want 1 0 0 0",
               busy, out_valid, pixel_x, pixel_y);
    end
    collect(0, '0, '0, done_iter);
    checks++;
    if (done_iter !== NPIX) begin
      errors++;
      $display("FAIL basic_done_cycle: frame_done at iter %0d, want %0d", done_iter, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      logic [COLOR_W-1:0] e = exp_q.pop_front();
      logic               el = exp_last_q.pop_front();
      logic [COLOR_W-1:0] g = (k < got_q.size()) ? got_q[k] : 'x;
      logic               gl = (k < got_last_q.size()) ? got_last_q[k] : 1'bx;
      checks++;
      if (g !== e || gl !== el) begin
        errors++;
        $display("FAIL basic_pixel%0d: data=%h last=%b, want data=%h last=%b", k, g, gl, e, el);
      end
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || got_q.size() != NPIX) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b beats=%0d, want 0 0 %0d",
               frame_done, busy, got_q.size(), NPIX);
    end
  endtask

  task automatic test_stall();
    int done_iter;
    color_base = 16'h0040;
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    collect(1, '0, '0, done_iter);
    checks++;
    if (stall_err != 0 || got_q.size() != NPIX) begin
      errors++;
      $display("FAIL stall_hold: violations=%0d beats=%0d, want 0 %0d",
               stall_err, got_q.size(), NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      logic [COLOR_W-1:0] e = exp_q.pop_front();
      logic               el = exp_last_q.pop_front();
      logic [COLOR_W-1:0] g = (k < got_q.size()) ? got_q[k] : 'x;
      logic               gl = (k < got_last_q.size()) ? got_last_q[k] : 1'bx;
      checks++;
      if (g !== e || gl !== el) begin
        errors++;
        $display("FAIL stall_pixel%0d: data=%h last=%b, want data=%h last=%b", k, g, gl, e, el);
      end
    end
    step();
  endtask

  task automatic test_snapshot();
    int done_iter;
    color_base = '0;
    ball_x_in = 9'd10; ball_y_in = 9'd11; paddle_1_x_in = 9'd12; paddle_1_y_in = 9'd13;
    paddle_2_x_in = 9'd14; paddle_2_y_in = 9'd15;
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    paddle_1_y_in = 9'd99;
    checks++;
    if ({ball_x, ball_y, paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y} !==
        {9'd10, 9'd11, 9'd12, 9'd13, 9'd14, 9'd15}) begin
      errors++;
      $display("FAIL snap_all: got %0d %0d %0d %0d %0d %0d, want 10 11 12 13 14 15",
               ball_x, ball_y, paddle_1_x, paddle_1_y, paddle_2_x, paddle_2_y);
    end
    collect(0, 9'd10, 9'd50, done_iter);
    checks++;
    if (ball_err != 0 || paddle_1_y !== 9'd13) begin
      errors++;
      $display("FAIL snap_hold: ball mismatches=%0d paddle_1_y=%0d, want 0 13", ball_err, paddle_1_y);
    end
    exp_q.delete();
    exp_last_q.delete();
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    checks++;
    if (ball_x !== 9'd50 || paddle_1_y !== 9'd99) begin
      errors++;
      $display("FAIL snap_next: ball_x=%0d paddle_1_y=%0d, want 50 99", ball_x, paddle_1_y);
    end
    collect(0, 9'd50, 9'd50, done_iter);
    exp_q.delete();
    exp_last_q.delete();
    step();
  endtask

  task automatic test_back_to_back();
    int done_iter;
    color_base = '0;
    start_frame = 1'b1;
    push_frame();
    step();
    collect(0, 9'd50, 9'd50, done_iter);
    checks++;
    if (done_iter !== NPIX || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: done iter=%0d busy=%b, want %0d 0", done_iter, busy, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      logic [COLOR_W-1:0] e = exp_q.pop_front();
      logic [COLOR_W-1:0] g = (k < got_q.size()) ? got_q[k] : 'x;
      void'(exp_last_q.pop_front());
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_f1_pixel%0d: data=%h, want %h", k, g, e);
      end
    end
    color_base = 16'h0100;
    push_frame();
    step();
    start_frame = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b valid=%b done=%b, want 1 0 0", busy, out_valid, frame_done);
    end
    collect(0, 9'd50, 9'd50, done_iter);
    checks++;
    if (done_iter !== NPIX || got_q.size() != NPIX) begin
      errors++;
      $display("FAIL b2b_second: done iter=%0d beats=%0d, want %0d %0d",
               done_iter, got_q.size(), NPIX, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      logic [COLOR_W-1:0] e = exp_q.pop_front();
      logic [COLOR_W-1:0] g = (k < got_q.size()) ? got_q[k] : 'x;
      void'(exp_last_q.pop_front());
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_f2_pixel%0d: data=%h, want %h", k, g, e);
      end
    end
    step();
  endtask

  task automatic test_reset_midframe();
    int done_iter;
    int done_seen = 0;
    color_base = '0;
    out_ready = 1'b1;
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    for (int i = 0; i < 6; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || pixel_x !== '0 || pixel_y !== '0 ||
        frame_done !== 1'b0 || out_data !== '0 || ball_x !== '0) begin
      errors++;
      $display("FAIL midreset_state: valid=%b busy=%b x=%0d y=%0d done=%b data=%h ball_x=%0d, want 0",
               out_valid, busy, pixel_x, pixel_y, frame_done, out_data, ball_x);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midreset_no_done: frame_done pulses=%0d, want 0", done_seen);
    end
    ball_x_in = 9'd7;
    start_frame = 1'b1;
    push_frame();
    step();
    start_frame = 1'b0;
    collect(0, 9'd7, 9'd7, done_iter);
    checks++;
    if (done_iter !== NPIX || got_q.size() != NPIX) begin
      errors++;
      $display("FAIL midreset_refill: done iter=%0d beats=%0d, want %0d %0d",
               done_iter, got_q.size(), NPIX, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      logic [COLOR_W-1:0] e = exp_q.pop_front();
      logic [COLOR_W-1:0] g = (k < got_q.size()) ? got_q[k] : 'x;
      void'(exp_last_q.pop_front());
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL midreset_pixel%0d: data=%h, want %h", k, g, e);
      end
    end
    step();
  endtask

  task automatic test_frame_count();
    int done_iter;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int f = 0; f < 3; f++) begin
      start_frame = 1'b1;
      step();
      start_frame = 1'b0;
      collect(0, 9'd7, 9'd7, done_iter);
      step();
    end
    checks++;
`ifdef FRAME_COUNT_EN
    if (frame_count !== 16'd3) begin
      errors++;
      $display("FAIL count_three: frame_count=%0d, want 3", frame_count);
    end
    dut.frame_count_q = 16'hFFFF;
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
    collect(0, 9'd7, 9'd7, done_iter);
    step();
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL count_wrap: frame_count=%h, want 0000", frame_count);
    end
`else
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL count_tied: frame_count=%0d, want 0", frame_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_back_to_back();
    test_reset_midframe();
    test_frame_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
